// File: rtl/id_scoreboard_if.sv
// -----------------------------------------------------------------------------
// id_scoreboard_if
//   Bundles the ID-stage issue handshake, the source/destination register
//   information of the instruction in ID, the retire (writeback) ports, the
//   flush strobe and the scoreboard status outputs.
//
//   Parameters
//     NREG  architectural registers tracked (r0 never tracked)
//     AW    register address width
//     NRP   source read ports checked per instruction
//     NWB   retire ports per cycle
//
//   Signals (direction seen from the scoreboard, i.e. the slave modport)
//     id_valid     in   ID holds a valid instruction
//     rs_addr      in   source addresses, port i at [i*AW +: AW]
//     rs_need      in   port i actually reads its register
//     fwd_hit      in   bypass network supplies port i's value this cycle
//     wr_en        in   ID instruction writes a register
//     wr_addr      in   ID destination register
//     exe_allowin  in   downstream stage accepts
//     id_ready_go  out  no unresolved hazard (combinational)
//     issue_fire   out  id_valid & id_ready_go & exe_allowin
//     wb_we        in   retire port j writes a register
//     wb_addr      in   retire port j address, port j at [j*AW +: AW]
//     flush        in   squash of all in-flight instructions
//     busy         out  busy[r] = in-flight count of r is non-zero, registered
//     sb_err       out  sticky: retire seen for a register with nothing in flight
// -----------------------------------------------------------------------------
interface id_scoreboard_if #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRP  = 2,
    parameter int NWB  = 1
);
    logic              id_valid;
    logic [NRP*AW-1:0] rs_addr;
    logic [NRP-1:0]    rs_need;
    logic [NRP-1:0]    fwd_hit;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic              exe_allowin;
    logic              id_ready_go;
    logic              issue_fire;
    logic [NWB-1:0]    wb_we;
    logic [NWB*AW-1:0] wb_addr;
    logic              flush;
    logic [NREG-1:0]   busy;
    logic              sb_err;

    // ID / pipeline side: drives the instruction and retire information.
    modport master (
        output id_valid, rs_addr, rs_need, fwd_hit, wr_en, wr_addr, exe_allowin,
        output wb_we, wb_addr, flush,
        input  id_ready_go, issue_fire, busy, sb_err
    );

    // Scoreboard side.
    modport slave (
        input  id_valid, rs_addr, rs_need, fwd_hit, wr_en, wr_addr, exe_allowin,
        input  wb_we, wb_addr, flush,
        output id_ready_go, issue_fire, busy, sb_err
    );
endinterface

// File: rtl/id_scoreboard.sv
// -----------------------------------------------------------------------------
// id_scoreboard
//   Register scoreboard for the ID stage. Keeps a small saturating-free
//   counter of in-flight writes per architectural register and decides
//   whether the instruction currently in ID may issue to EXE.
//
//   Parameters
//     NREG   architectural registers (r0 is never tracked)
//     AW     register address width, = clog2(NREG)
//     NRP    source read ports checked per instruction
//     NWB    retire ports per cycle
//     CNT_W  per-register counter width (up to 2^CNT_W-1 outstanding writes)
//
//   Ports
//     clk     in   clock, all state updates on its rising edge
//     resetn  in   synchronous, active-low reset
//     sb      --   id_scoreboard_if.slave: handshake, register info, retire
//                  ports, flush, and the id_ready_go/issue_fire/busy/sb_err
//                  outputs
//
//   Behaviour summary
//     - A source port is a hazard when it is needed, is not r0, its register
//       has writes in flight and the bypass network cannot supply it.
//     - A writer is held back when its destination counter is already full,
//       unless a retire to that register in the same cycle frees a slot.
//     - Each cycle a counter moves by (+1 for an issuing writer) - (number of
//       retire ports hitting it). Going below zero clamps to 0 and raises the
//       sticky sb_err flag.
//     - flush zeroes every counter (the ID instruction is not counted) but
//       keeps sb_err; resetn clears everything and wins over flush.
// -----------------------------------------------------------------------------
module id_scoreboard #(
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int NRP   = 2,
    parameter int NWB   = 1,
    parameter int CNT_W = 2
) (
    input  logic           clk,
    input  logic           resetn,
    id_scoreboard_if.slave sb
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    // Width able to hold cnt+1 as well as the retire count 0..NWB, so the
    // underflow test is a plain unsigned compare.
    localparam int DW = $clog2(NWB + 1);
    localparam int SW = (CNT_W + 1 > DW) ? CNT_W + 1 : DW;

    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic [SW-1:0]    up_v    [NREG];
    logic [SW-1:0]    dn_v    [NREG];

    logic [AW-1:0]    rs_a    [NRP];
    logic [AW-1:0]    wb_a    [NWB];

    logic [NREG-1:0]  busy_q;
    logic             sb_err_q;
    logic             err_set;
    logic             hazard;
    logic             wb_hits_wr;
    logic             saturate;
    logic             ready_go;
    logic             fire;

    // -------------------------------------------------------------------------
    // Unpack the flat address buses into per-port views.
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < NRP; i++) begin : g_rs
        assign rs_a[i] = sb.rs_addr[i*AW +: AW];
    end

    for (genvar j = 0; j < NWB; j++) begin : g_wb
        assign wb_a[j] = sb.wb_addr[j*AW +: AW];
    end

    // -------------------------------------------------------------------------
    // Issue decision. Depends only on inputs and the current counters; busy
    // is not used here because it lags the counters by nothing but would tie
    // the decision to an extra register copy.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written in this block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        hazard     = 1'b0;
        wb_hits_wr = 1'b0;

        for (int i = 0; i < NRP; i++) begin
            if (sb.id_valid && sb.rs_need[i] && (rs_a[i] != '0) &&
                (cnt[rs_a[i]] != '0) && !sb.fwd_hit[i]) begin
                hazard = 1'b1;
            end
        end

        // A retire to the destination in the same cycle frees one slot, so
        // a full counter does not block that writer.
        for (int j = 0; j < NWB; j++) begin
            if (sb.wb_we[j] && (wb_a[j] == sb.wr_addr)) begin
                wb_hits_wr = 1'b1;
            end
        end

        saturate = sb.id_valid && sb.wr_en && (sb.wr_addr != '0) &&
                   (cnt[sb.wr_addr] == CNT_MAX) && !wb_hits_wr;

        ready_go = !(hazard || saturate);
        fire     = sb.id_valid && ready_go && sb.exe_allowin;
    end

    // -------------------------------------------------------------------------
    // Counter next-state. up_v is cnt plus an issuing writer, dn_v counts the
    // retire ports hitting the register; dn_v > up_v means a retire arrived
    // for a write that was never counted.
    // -------------------------------------------------------------------------
    always_comb begin
        err_set = 1'b0;

        for (int r = 0; r < NREG; r++) begin
            up_v[r]    = SW'(cnt[r]);
            dn_v[r]    = '0;
            cnt_nxt[r] = cnt[r];

            if (fire && sb.wr_en && (sb.wr_addr == AW'(r))) begin
                up_v[r] = up_v[r] + SW'(1);
            end

            for (int j = 0; j < NWB; j++) begin
                if (sb.wb_we[j] && (wb_a[j] == AW'(r))) begin
                    dn_v[r] = dn_v[r] + SW'(1);
                end
            end

            if (r == 0) begin
                // r0 is hard-wired zero: never counted, never flags an error.
                cnt_nxt[r] = '0;
            end else if (dn_v[r] > up_v[r]) begin
                cnt_nxt[r] = '0;
                err_set    = 1'b1;
            end else begin
                cnt_nxt[r] = CNT_W'(up_v[r] - dn_v[r]);
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers. Priority: reset, then flush, then normal update.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values present before this edge.
        if (!resetn) begin
            // NOTE: the counter array is reset explicitly; a stale count after
            // reset would stall ID forever, so it cannot be left to RAM init.
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            busy_q   <= '0;
            sb_err_q <= 1'b0;
        end else if (sb.flush) begin
            // Squash: nothing remains in flight, the ID instruction included.
            // sb_err is deliberately kept so a prior error stays visible.
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r]    <= cnt_nxt[r];
                busy_q[r] <= (cnt_nxt[r] != '0);
            end
            sb_err_q <= sb_err_q | err_set;
        end
    end

    assign sb.id_ready_go = ready_go;
    assign sb.issue_fire  = fire;
    assign sb.busy        = busy_q;
    assign sb.sb_err      = sb_err_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_id_scoreboard
//   Self-checking bench for id_scoreboard with NRP=2, NWB=2, CNT_W=2.
//   A reference model keeps an integer in-flight count per register and
//   applies the issue/retire/flush/reset rules directly. Directed steps cover
//   the named scenarios, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_id_scoreboard;

    localparam int NREG  = 32;
    localparam int AW    = 5;
    localparam int NRP   = 2;
    localparam int NWB   = 2;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    id_scoreboard_if #(.NREG(NREG), .AW(AW), .NRP(NRP), .NWB(NWB)) sbi ();

    id_scoreboard #(
        .NREG (NREG),
        .AW   (AW),
        .NRP  (NRP),
        .NWB  (NWB),
        .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .sb    (sbi.slave)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model state.
    int mcnt [NREG];
    bit merr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] rs_at(input int i);
        return sbi.rs_addr[i*AW +: AW];
    endfunction

    function automatic logic [AW-1:0] wb_at(input int j);
        return sbi.wb_addr[j*AW +: AW];
    endfunction

    function automatic bit model_ready();
        bit haz = 0;
        bit freed = 0;
        bit sat;
        for (int i = 0; i < NRP; i++) begin
            if (sbi.id_valid && sbi.rs_need[i] && rs_at(i) != 0 &&
                mcnt[rs_at(i)] > 0 && !sbi.fwd_hit[i]) haz = 1;
        end
        for (int j = 0; j < NWB; j++) begin
            if (sbi.wb_we[j] && wb_at(j) == sbi.wr_addr) freed = 1;
        end
        sat = sbi.id_valid && sbi.wr_en && sbi.wr_addr != 0 &&
              mcnt[sbi.wr_addr] == CMAX && !freed;
        return !(haz || sat);
    endfunction

    function automatic logic [NREG-1:0] model_busy();
        logic [NREG-1:0] b = '0;
        for (int r = 1; r < NREG; r++) b[r] = (mcnt[r] != 0);
        return b;
    endfunction

    task automatic idle_inputs();
        sbi.id_valid    = 1'b0;
        sbi.rs_addr     = '0;
        sbi.rs_need     = '0;
        sbi.fwd_hit     = '0;
        sbi.wr_en       = 1'b0;
        sbi.wr_addr     = '0;
        sbi.exe_allowin = 1'b1;
        sbi.wb_we       = '0;
        sbi.wb_addr     = '0;
        sbi.flush       = 1'b0;
    endtask

    task automatic set_write(input int addr);
        sbi.id_valid = 1'b1;
        sbi.wr_en    = 1'b1;
        sbi.wr_addr  = AW'(addr);
    endtask

    task automatic set_retire(input int j, input int addr);
        sbi.wb_we[j]           = 1'b1;
        sbi.wb_addr[j*AW +: AW] = AW'(addr);
    endtask

    // One clock cycle: check the combinational issue outputs against the
    // model, advance the model, then check the registered outputs after the
    // edge. want_ready >= 0 adds a fixed expectation for id_ready_go.
    task automatic step(input string tag, input int want_ready = -1);
        bit exp_ready, exp_fire;
        int delta [NREG];
        #1;
        exp_ready = model_ready();
        exp_fire  = sbi.id_valid && exp_ready && sbi.exe_allowin;
        chk({tag, "/ready"}, sbi.id_ready_go, exp_ready);
        chk({tag, "/fire"},  sbi.issue_fire,  exp_fire);
        if (want_ready >= 0) chk({tag, "/ready_fixed"}, sbi.id_ready_go, want_ready[0]);

        if (!resetn) begin
            foreach (mcnt[r]) mcnt[r] = 0;
            merr = 0;
        end else if (sbi.flush) begin
            foreach (mcnt[r]) mcnt[r] = 0;
        end else begin
            foreach (delta[r]) delta[r] = 0;
            if (exp_fire && sbi.wr_en && sbi.wr_addr != 0) delta[sbi.wr_addr]++;
            for (int j = 0; j < NWB; j++)
                if (sbi.wb_we[j] && wb_at(j) != 0) delta[wb_at(j)]--;
            for (int r = 1; r < NREG; r++) begin
                mcnt[r] += delta[r];
                if (mcnt[r] < 0) begin
                    mcnt[r] = 0;
                    merr    = 1;
                end
            end
        end

        @(posedge clk);
        #1;
        chk({tag, "/busy"},   sbi.busy,   model_busy());
        chk({tag, "/sb_err"}, sbi.sb_err, merr);
    endtask

    initial begin
        foreach (mcnt[r]) mcnt[r] = 7;   // unknown until the first reset edge
        merr = 0;
        idle_inputs();

        // 1: reset, then idle
        resetn = 1'b0;
        step("rst0");
        step("rst1");
        resetn = 1'b1;
        chk("t1_busy", sbi.busy, 0);
        chk("t1_err", sbi.sb_err, 0);
        step("t1_idle", 1);

        // 2: load writes r5, consumer stalls until bypass, retire clears busy
        set_write(5);
        step("t2_issue", 1);
        chk("t2_busy5", sbi.busy[5], 1);
        idle_inputs();
        sbi.id_valid = 1'b1;
        sbi.rs_addr[0 +: AW] = 5'd5;
        sbi.rs_need[0] = 1'b1;
        step("t2_stall", 0);
        sbi.fwd_hit[0] = 1'b1;
        sbi.exe_allowin = 1'b0;
        step("t2_fwd", 1);
        idle_inputs();
        set_retire(0, 5);
        step("t2_wb");
        chk("t2_busy5_clr", sbi.busy[5], 0);

        // 3: three writers fill r7; fourth stalls unless r7 retires same cycle
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            set_write(7);
            step("t3_fill", 1);
        end
        set_write(7);
        sbi.exe_allowin = 1'b1;
        step("t3_sat", 0);
        set_retire(0, 7);
        step("t3_sat_wb", 1);
        idle_inputs();
        set_retire(0, 7);
        step("t3_drain1");
        step("t3_drain2");
        chk("t3_busy7_still", sbi.busy[7], 1);
        step("t3_drain3");
        chk("t3_busy7_clr", sbi.busy[7], 0);
        chk("t3_err", sbi.sb_err, 0);

        // 4: two retires to r9 in one cycle
        idle_inputs();
        set_write(9);
        step("t4_w1");
        step("t4_w2");
        idle_inputs();
        set_retire(0, 9);
        set_retire(1, 9);
        step("t4_dual_wb");
        chk("t4_busy9", sbi.busy[9], 0);
        chk("t4_err", sbi.sb_err, 0);

        // 5: flush beats a same-cycle issue; spurious retire sets sticky error
        idle_inputs();
        set_write(3);
        step("t5_w3");
        set_write(4);
        step("t5_w4");
        set_write(6);
        sbi.flush = 1'b1;
        step("t5_flush", 1);
        chk("t5_busy_all", sbi.busy, 0);
        idle_inputs();
        set_retire(0, 12);
        step("t5_spurious");
        chk("t5_err_set", sbi.sb_err, 1);
        idle_inputs();
        step("t5_hold");
        sbi.flush = 1'b1;
        step("t5_flush_keep");
        chk("t5_err_kept", sbi.sb_err, 1);
        idle_inputs();
        resetn = 1'b0;
        step("t5_reset");
        resetn = 1'b1;
        chk("t5_err_clr", sbi.sb_err, 0);

        // 6: r0 is never tracked
        idle_inputs();
        set_write(0);
        sbi.rs_need = 2'b11;
        step("t6_w0", 1);
        step("t6_w0b", 1);
        set_retire(1, 0);
        step("t6_wb0", 1);
        chk("t6_busy0", sbi.busy[0], 0);
        chk("t6_err", sbi.sb_err, 0);

        // Randomized run against the model
        for (int n = 0; n < 400; n++) begin
            resetn          = ($urandom_range(0, 99) != 0);
            sbi.id_valid    = ($urandom_range(0, 3) != 0);
            sbi.rs_addr     = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            sbi.rs_need     = 2'($urandom_range(0, 3));
            sbi.fwd_hit     = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            sbi.wr_en       = ($urandom_range(0, 1) != 0);
            sbi.wr_addr     = AW'($urandom_range(0, 7));
            sbi.exe_allowin = ($urandom_range(0, 3) != 0);
            sbi.wb_we       = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            sbi.wb_addr     = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            sbi.flush       = ($urandom_range(0, 49) == 0);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
